// File: rtl/sdr_sdram_16_wb_arb2.sv
// sdr_sdram_16_wb_arb2: round-robin two-master Wishbone arbiter in front of the SDRAM controller slave port.
// Grant is held for the whole bus cycle; the slave is released to IDLE for one cycle between owners.
module sdr_sdram_16_wb_arb2 #(
    parameter int adr_width = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          m0_dat_i,
    input  logic [adr_width:1]   m0_adr_i,
    input  logic [3:0]           m0_sel_i,
    input  logic [1:0]           m0_bte_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    output logic [31:0]          m0_dat_o,
    output logic                 m0_ack_o,
    input  logic [31:0]          m1_dat_i,
    input  logic [adr_width:1]   m1_adr_i,
    input  logic [3:0]           m1_sel_i,
    input  logic [1:0]           m1_bte_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    output logic [31:0]          m1_dat_o,
    output logic                 m1_ack_o,
    output logic [31:0]          s_dat_o,
    output logic [adr_width:1]   s_adr_o,
    output logic [3:0]           s_sel_o,
    output logic [1:0]           s_bte_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    output logic [1:0]           gnt_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state_q, state_d;
    logic   last_q, last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // On a tie master 0 wins unless it was the last owner.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                      state_d = GNT0;
                      last_d  = 1'b0;
                  end else if (m1_cyc_i) begin
                      state_d = GNT1;
                      last_d  = 1'b1;
                  end
            GNT0: state_d = m0_cyc_i ? GNT0 : IDLE;
            GNT1: state_d = m1_cyc_i ? GNT1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign gnt_o    = {state_q == GNT1, state_q == GNT0};
    assign s_dat_o  = gnt_o[1] ? m1_dat_i : m0_dat_i;
    assign s_adr_o  = gnt_o[1] ? m1_adr_i : m0_adr_i;
    assign s_sel_o  = gnt_o[1] ? m1_sel_i : m0_sel_i;
    assign s_bte_o  = gnt_o[1] ? m1_bte_i : m0_bte_i;
    assign s_we_o   = gnt_o[1] ? m1_we_i  : m0_we_i;
    assign s_cyc_o  = (gnt_o[0] & m0_cyc_i) | (gnt_o[1] & m1_cyc_i);
    assign s_stb_o  = (gnt_o[0] & m0_cyc_i & m0_stb_i) | (gnt_o[1] & m1_cyc_i & m1_stb_i);
    assign m0_ack_o = s_ack_i & gnt_o[0];
    assign m1_ack_o = s_ack_i & gnt_o[1];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
endmodule
